// File: rtl/cve2_obi_port_arbiter_if.sv
// Bundles the instruction-fetch, LSU and shared memory-port signals of the
// OBI port arbiter. Signal suffixes are from the arbiter's point of view.
interface cve2_obi_port_arbiter_if;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        instr_err_o;

  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        data_err_o;

  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        mem_err_i;

  modport slave (
    input  instr_req_i, instr_addr_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i
  );

  modport master (
    output instr_req_i, instr_addr_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i
  );
endinterface

// File: rtl/cve2_obi_port_arbiter.sv
// Shares one OBI memory port between instruction fetch and the LSU; a small
// source-ID FIFO steers each rvalid back to the requester that issued it.
module cve2_obi_port_arbiter #(
  parameter int unsigned MaxOutstanding = 2,
  parameter bit          DataPriority   = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  cve2_obi_port_arbiter_if.slave bus,
  output logic                   busy_o
);
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  typedef enum logic {SRC_INSTR = 1'b0, SRC_DATA = 1'b1} src_e;
  typedef enum logic [1:0] {LOCK_NONE, LOCK_INSTR, LOCK_DATA} lock_e;

  lock_e           lock_q, lock_d;
  src_e            rr_last_q, rr_last_d;
  src_e            sel;
  src_e            head_src;
  src_e            fifo_q [MaxOutstanding];
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic            can_issue, sel_data, mem_req, push, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // A stalled request keeps the port until granted, whatever the other side wants.
  always_comb begin
    sel = SRC_INSTR;
    unique case (lock_q)
      LOCK_INSTR: sel = SRC_INSTR;
      LOCK_DATA:  sel = SRC_DATA;
      default: begin
        if (bus.data_req_i && bus.instr_req_i)
          sel = (DataPriority || rr_last_q == SRC_INSTR) ? SRC_DATA : SRC_INSTR;
        else if (bus.data_req_i)
          sel = SRC_DATA;
      end
    endcase
  end

  assign sel_data  = (sel == SRC_DATA);
  assign can_issue = (count_q < CntW'(MaxOutstanding));
  assign mem_req   = can_issue & (sel_data ? bus.data_req_i : bus.instr_req_i);
  assign push      = mem_req & bus.mem_gnt_i;
  assign pop       = bus.mem_rvalid_i & (count_q != '0);
  assign head_src  = fifo_q[rptr_q];

  always_comb begin
    lock_d    = lock_q;
    rr_last_d = rr_last_q;
    count_d   = count_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    if (bus.mem_gnt_i)
      lock_d = LOCK_NONE;
    else if (mem_req)
      lock_d = sel_data ? LOCK_DATA : LOCK_INSTR;
    if (push) begin
      rr_last_d = sel;
      wptr_d    = ptr_inc(wptr_q);
    end
    if (pop)
      rptr_d = ptr_inc(rptr_q);
    if (push && !pop)
      count_d = count_q + CntW'(1);
    else if (pop && !push)
      count_d = count_q - CntW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q    <= LOCK_NONE;
      rr_last_q <= SRC_INSTR;
      count_q   <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
    end else begin
      lock_q    <= lock_d;
      rr_last_q <= rr_last_d;
      count_q   <= count_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
    end
  end

  for (genvar gi = 0; gi < MaxOutstanding; gi++) begin : g_fifo
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
        fifo_q[gi] <= SRC_INSTR;
      else if (push && wptr_q == PtrW'(gi))
        fifo_q[gi] <= sel;
    end
  end

  // Payload is zeroed when idle so the port shows no stale attributes.
  assign bus.mem_req_o   = mem_req;
  assign bus.mem_we_o    = mem_req & sel_data & bus.data_we_i;
  assign bus.mem_be_o    = !mem_req ? 4'h0  : (sel_data ? bus.data_be_i    : 4'hF);
  assign bus.mem_addr_o  = !mem_req ? 32'h0 : (sel_data ? bus.data_addr_i  : bus.instr_addr_i);
  assign bus.mem_wdata_o = !mem_req ? 32'h0 : (sel_data ? bus.data_wdata_i : 32'h0);

  assign bus.instr_gnt_o    = push & ~sel_data;
  assign bus.data_gnt_o     = push & sel_data;
  assign bus.instr_rvalid_o = pop & (head_src == SRC_INSTR);
  assign bus.data_rvalid_o  = pop & (head_src == SRC_DATA);
  assign bus.instr_rdata_o  = bus.mem_rdata_i;
  assign bus.data_rdata_o   = bus.mem_rdata_i;
  assign bus.instr_err_o    = bus.mem_err_i;
  assign bus.data_err_o     = bus.mem_err_i;

  assign busy_o = (count_q != '0) | (lock_q != LOCK_NONE);

  a_no_x: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !$isunknown({bus.mem_req_o, bus.instr_gnt_o, bus.data_gnt_o}));
  a_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (bus.mem_req_o && !bus.mem_gnt_i) |=>
      $stable({bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o}));
  a_count: assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_q <= CntW'(MaxOutstanding));
  a_no_stray_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus.mem_rvalid_i |-> (count_q != '0));
endmodule

// File: tb/tb_cve2_obi_port_arbiter.sv
// Directed bench: one DUT with data priority, one with round-robin arbitration.
module tb_cve2_obi_port_arbiter;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic busy_p, busy_r;
  int   checks = 0;
  int   failures = 0;

  always #5 clk_i = ~clk_i;

  cve2_obi_port_arbiter_if bus_p();
  cve2_obi_port_arbiter_if bus_r();

  cve2_obi_port_arbiter #(.MaxOutstanding(2), .DataPriority(1'b1)) u_dut_prio (
    .clk_i(clk_i), .rst_ni(rst_ni), .bus(bus_p), .busy_o(busy_p));
  cve2_obi_port_arbiter #(.MaxOutstanding(2), .DataPriority(1'b0)) u_dut_rr (
    .clk_i(clk_i), .rst_ni(rst_ni), .bus(bus_r), .busy_o(busy_r));

  task automatic idle_p();
    bus_p.instr_req_i = 0; bus_p.instr_addr_i = 0;
    bus_p.data_req_i = 0; bus_p.data_we_i = 0; bus_p.data_be_i = 0;
    bus_p.data_addr_i = 0; bus_p.data_wdata_i = 0;
    bus_p.mem_gnt_i = 0; bus_p.mem_rvalid_i = 0; bus_p.mem_rdata_i = 0; bus_p.mem_err_i = 0;
  endtask

  task automatic idle_r();
    bus_r.instr_req_i = 0; bus_r.instr_addr_i = 0;
    bus_r.data_req_i = 0; bus_r.data_we_i = 0; bus_r.data_be_i = 0;
    bus_r.data_addr_i = 0; bus_r.data_wdata_i = 0;
    bus_r.mem_gnt_i = 0; bus_r.mem_rvalid_i = 0; bus_r.mem_rdata_i = 0; bus_r.mem_err_i = 0;
  endtask

  task automatic test_reset();
    @(negedge clk_i); #1;
    checks++; if (bus_p.mem_req_o !== 1'b0) begin failures++; $display("FAIL rst_req: got %0b expected 0", bus_p.mem_req_o); end
    checks++; if (bus_p.mem_be_o !== 4'h0) begin failures++; $display("FAIL rst_be: got %0h expected 0", bus_p.mem_be_o); end
    checks++; if ({bus_p.instr_gnt_o, bus_p.data_gnt_o, bus_p.instr_rvalid_o, bus_p.data_rvalid_o} !== 4'b0) begin failures++; $display("FAIL rst_hs: got %b expected 0000", {bus_p.instr_gnt_o, bus_p.data_gnt_o, bus_p.instr_rvalid_o, bus_p.data_rvalid_o}); end
    checks++; if ({busy_p, busy_r, bus_r.mem_req_o} !== 3'b0) begin failures++; $display("FAIL rst_busy: got %b expected 000", {busy_p, busy_r, bus_r.mem_req_o}); end
    @(negedge clk_i); rst_ni = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_single_fetch();
    @(negedge clk_i); bus_p.instr_req_i = 1; bus_p.instr_addr_i = 32'h100; bus_p.mem_gnt_i = 1; #1;
    checks++; if (bus_p.instr_gnt_o !== 1'b1 || bus_p.data_gnt_o !== 1'b0) begin failures++; $display("FAIL fetch_gnt: got i=%0b d=%0b expected i=1 d=0", bus_p.instr_gnt_o, bus_p.data_gnt_o); end
    checks++; if ({bus_p.mem_addr_o, bus_p.mem_be_o, bus_p.mem_we_o} !== {32'h100, 4'hF, 1'b0}) begin failures++; $display("FAIL fetch_payload: got addr=%0h be=%0h we=%0b expected 100 f 0", bus_p.mem_addr_o, bus_p.mem_be_o, bus_p.mem_we_o); end
    @(negedge clk_i); idle_p(); bus_p.mem_rvalid_i = 1; bus_p.mem_rdata_i = 32'hDEADBEEF; bus_p.mem_err_i = 1; #1;
    checks++; if (bus_p.instr_rvalid_o !== 1'b1 || bus_p.data_rvalid_o !== 1'b0) begin failures++; $display("FAIL fetch_rvalid: got i=%0b d=%0b expected i=1 d=0", bus_p.instr_rvalid_o, bus_p.data_rvalid_o); end
    checks++; if (bus_p.instr_rdata_o !== 32'hDEADBEEF || bus_p.data_rdata_o !== 32'hDEADBEEF) begin failures++; $display("FAIL fetch_rdata: got %0h/%0h expected deadbeef", bus_p.instr_rdata_o, bus_p.data_rdata_o); end
    checks++; if ({bus_p.instr_err_o, bus_p.data_err_o, busy_p} !== 3'b111) begin failures++; $display("FAIL fetch_err_busy: got %b expected 111", {bus_p.instr_err_o, bus_p.data_err_o, busy_p}); end
    @(negedge clk_i); idle_p(); #1;
    checks++; if (busy_p !== 1'b0) begin failures++; $display("FAIL fetch_idle: got busy=%0b expected 0", busy_p); end
    $display("test_single_fetch done");
  endtask

  task automatic test_data_priority();
    @(negedge clk_i);
    bus_p.instr_req_i = 1; bus_p.instr_addr_i = 32'h200;
    bus_p.data_req_i = 1; bus_p.data_we_i = 1; bus_p.data_be_i = 4'b0011;
    bus_p.data_addr_i = 32'h1000; bus_p.data_wdata_i = 32'h55; bus_p.mem_gnt_i = 1; #1;
    checks++; if (bus_p.data_gnt_o !== 1'b1 || bus_p.instr_gnt_o !== 1'b0) begin failures++; $display("FAIL prio_first: got i=%0b d=%0b expected i=0 d=1", bus_p.instr_gnt_o, bus_p.data_gnt_o); end
    checks++; if ({bus_p.mem_addr_o, bus_p.mem_wdata_o, bus_p.mem_be_o, bus_p.mem_we_o} !== {32'h1000, 32'h55, 4'b0011, 1'b1}) begin failures++; $display("FAIL prio_payload: got addr=%0h wdata=%0h be=%0h we=%0b expected 1000 55 3 1", bus_p.mem_addr_o, bus_p.mem_wdata_o, bus_p.mem_be_o, bus_p.mem_we_o); end
    @(negedge clk_i); bus_p.data_req_i = 0; #1;
    checks++; if (bus_p.instr_gnt_o !== 1'b1 || bus_p.mem_addr_o !== 32'h200 || bus_p.mem_wdata_o !== 32'h0) begin failures++; $display("FAIL prio_second: got gnt=%0b addr=%0h wdata=%0h expected 1 200 0", bus_p.instr_gnt_o, bus_p.mem_addr_o, bus_p.mem_wdata_o); end
    @(negedge clk_i); idle_p(); bus_p.mem_rvalid_i = 1; bus_p.mem_rdata_i = 32'h11; #1;
    checks++; if ({bus_p.data_rvalid_o, bus_p.instr_rvalid_o} !== 2'b10) begin failures++; $display("FAIL prio_resp1: got d,i=%b expected 10", {bus_p.data_rvalid_o, bus_p.instr_rvalid_o}); end
    @(negedge clk_i); bus_p.mem_rdata_i = 32'h22; #1;
    checks++; if ({bus_p.data_rvalid_o, bus_p.instr_rvalid_o} !== 2'b01 || bus_p.instr_rdata_o !== 32'h22) begin failures++; $display("FAIL prio_resp2: got d,i=%b rdata=%0h expected 01 22", {bus_p.data_rvalid_o, bus_p.instr_rvalid_o}, bus_p.instr_rdata_o); end
    @(negedge clk_i); idle_p(); #1;
    checks++; if (busy_p !== 1'b0) begin failures++; $display("FAIL prio_idle: got busy=%0b expected 0", busy_p); end
    $display("test_data_priority done");
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_gnt [4];
    logic [1:0] exp_rv  [4];
    // {data, instr} per cycle: grants alternate starting with DATA
    exp_gnt[0] = 2'b10; exp_gnt[1] = 2'b01; exp_gnt[2] = 2'b10; exp_gnt[3] = 2'b01;
    exp_rv[0]  = 2'b00; exp_rv[1]  = 2'b10; exp_rv[2]  = 2'b01; exp_rv[3]  = 2'b10;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      bus_r.instr_req_i = 1; bus_r.instr_addr_i = 32'h300 + 32'(i * 4);
      bus_r.data_req_i = 1; bus_r.data_addr_i = 32'h2000 + 32'(i * 4); bus_r.data_be_i = 4'hF;
      bus_r.mem_gnt_i = 1; bus_r.mem_rvalid_i = (i != 0); #1;
      checks++; if ({bus_r.data_gnt_o, bus_r.instr_gnt_o} !== exp_gnt[i]) begin failures++; $display("FAIL rr_gnt%0d: got d,i=%b expected %b", i, {bus_r.data_gnt_o, bus_r.instr_gnt_o}, exp_gnt[i]); end
      checks++; if ({bus_r.data_rvalid_o, bus_r.instr_rvalid_o} !== exp_rv[i]) begin failures++; $display("FAIL rr_rv%0d: got d,i=%b expected %b", i, {bus_r.data_rvalid_o, bus_r.instr_rvalid_o}, exp_rv[i]); end
    end
    @(negedge clk_i); idle_r(); bus_r.mem_rvalid_i = 1; #1;
    checks++; if ({bus_r.data_rvalid_o, bus_r.instr_rvalid_o} !== 2'b01) begin failures++; $display("FAIL rr_last_resp: got d,i=%b expected 01", {bus_r.data_rvalid_o, bus_r.instr_rvalid_o}); end
    @(negedge clk_i); idle_r(); #1;
    checks++; if (busy_r !== 1'b0) begin failures++; $display("FAIL rr_idle: got busy=%0b expected 0", busy_r); end
    $display("test_round_robin done");
  endtask

  task automatic test_lock();
    @(negedge clk_i);
    bus_r.data_req_i = 1; bus_r.data_we_i = 1; bus_r.data_be_i = 4'hF;
    bus_r.data_addr_i = 32'h3000; bus_r.data_wdata_i = 32'hA5; bus_r.mem_gnt_i = 1; #1;
    checks++; if (bus_r.data_gnt_o !== 1'b1) begin failures++; $display("FAIL lock_pre_gnt: got %0b expected 1", bus_r.data_gnt_o); end
    @(negedge clk_i); bus_r.data_addr_i = 32'h3004; bus_r.mem_gnt_i = 0; bus_r.mem_rvalid_i = 1; #1;
    checks++; if (bus_r.data_rvalid_o !== 1'b1 || bus_r.mem_req_o !== 1'b1 || bus_r.data_gnt_o !== 1'b0) begin failures++; $display("FAIL lock_stall0: got rv=%0b req=%0b gnt=%0b expected 1 1 0", bus_r.data_rvalid_o, bus_r.mem_req_o, bus_r.data_gnt_o); end
    // rr_last is now DATA, so without the lock instr would win these cycles
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i); bus_r.mem_rvalid_i = 0; bus_r.instr_req_i = 1; bus_r.instr_addr_i = 32'h400; #1;
      checks++; if ({bus_r.mem_addr_o, bus_r.mem_we_o, bus_r.instr_gnt_o} !== {32'h3004, 1'b1, 1'b0}) begin failures++; $display("FAIL lock_hold%0d: got addr=%0h we=%0b igпосле=%0b expected 3004 1 0", i, bus_r.mem_addr_o, bus_r.mem_we_o, bus_r.instr_gnt_o); end
      checks++; if (busy_r !== 1'b1) begin failures++; $display("FAIL lock_busy%0d: got %0b expected 1", i, busy_r); end
    end
    @(negedge clk_i); bus_r.mem_gnt_i = 1; #1;
    checks++; if ({bus_r.data_gnt_o, bus_r.instr_gnt_o} !== 2'b10 || bus_r.mem_addr_o !== 32'h3004) begin failures++; $display("FAIL lock_release: got d,i=%b addr=%0h expected 10 3004", {bus_r.data_gnt_o, bus_r.instr_gnt_o}, bus_r.mem_addr_o); end
    @(negedge clk_i); bus_r.data_req_i = 0; #1;
    checks++; if (bus_r.instr_gnt_o !== 1'b1 || bus_r.mem_addr_o !== 32'h400) begin failures++; $display("FAIL lock_instr_after: got gnt=%0b addr=%0h expected 1 400", bus_r.instr_gnt_o, bus_r.mem_addr_o); end
    @(negedge clk_i); idle_r(); bus_r.mem_rvalid_i = 1; #1;
    checks++; if ({bus_r.data_rvalid_o, bus_r.instr_rvalid_o} !== 2'b10) begin failures++; $display("FAIL lock_resp1: got d,i=%b expected 10", {bus_r.data_rvalid_o, bus_r.instr_rvalid_o}); end
    @(negedge clk_i); #1;
    checks++; if ({bus_r.data_rvalid_o, bus_r.instr_rvalid_o} !== 2'b01) begin failures++; $display("FAIL lock_resp2: got d,i=%b expected 01", {bus_r.data_rvalid_o, bus_r.instr_rvalid_o}); end
    @(negedge clk_i); idle_r(); #1;
    checks++; if (busy_r !== 1'b0) begin failures++; $display("FAIL lock_idle: got busy=%0b expected 0", busy_r); end
    $display("test_lock done");
  endtask

  task automatic test_full_gating();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i); bus_p.instr_req_i = 1; bus_p.instr_addr_i = 32'h500 + 32'(i * 4); bus_p.mem_gnt_i = 1; #1;
      checks++; if (bus_p.instr_gnt_o !== 1'b1) begin failures++; $display("FAIL full_fill%0d: got gnt=%0b expected 1", i, bus_p.instr_gnt_o); end
    end
    @(negedge clk_i); bus_p.instr_addr_i = 32'h508; #1;
    checks++; if (bus_p.mem_req_o !== 1'b0 || bus_p.instr_gnt_o !== 1'b0) begin failures++; $display("FAIL full_block: got req=%0b gnt=%0b expected 0 0", bus_p.mem_req_o, bus_p.instr_gnt_o); end
    @(negedge clk_i); bus_p.mem_rvalid_i = 1; #1;
    checks++; if (bus_p.mem_req_o !== 1'b0 || bus_p.instr_rvalid_o !== 1'b1) begin failures++; $display("FAIL full_no_bypass: got req=%0b rv=%0b expected 0 1", bus_p.mem_req_o, bus_p.instr_rvalid_o); end
    @(negedge clk_i); bus_p.mem_rvalid_i = 0; #1;
    checks++; if (bus_p.instr_gnt_o !== 1'b1 || bus_p.mem_addr_o !== 32'h508) begin failures++; $display("FAIL full_reissue: got gnt=%0b addr=%0h expected 1 508", bus_p.instr_gnt_o, bus_p.mem_addr_o); end
    $display("test_full_gating done");
  endtask

  task automatic test_reset_outstanding();
    @(negedge clk_i); idle_p(); #1;
    checks++; if (busy_p !== 1'b1) begin failures++; $display("FAIL rstout_busy_before: got %0b expected 1", busy_p); end
    rst_ni = 1'b0; #1;
    checks++; if ({busy_p, bus_p.mem_req_o, bus_p.instr_gnt_o, bus_p.data_gnt_o} !== 4'b0) begin failures++; $display("FAIL rstout_clear: got %b expected 0000", {busy_p, bus_p.mem_req_o, bus_p.instr_gnt_o, bus_p.data_gnt_o}); end
    // a late response for a discarded ID must not reach either requester
    bus_p.mem_rvalid_i = 1; bus_p.mem_rdata_i = 32'h77; #1;
    checks++; if ({bus_p.instr_rvalid_o, bus_p.data_rvalid_o} !== 2'b00) begin failures++; $display("FAIL rstout_stray: got i,d=%b expected 00", {bus_p.instr_rvalid_o, bus_p.data_rvalid_o}); end
    @(negedge clk_i); #1;
    checks++; if ({bus_p.instr_rvalid_o, bus_p.data_rvalid_o} !== 2'b00) begin failures++; $display("FAIL rstout_stray2: got i,d=%b expected 00", {bus_p.instr_rvalid_o, bus_p.data_rvalid_o}); end
    @(negedge clk_i); idle_p(); rst_ni = 1'b1;
    @(negedge clk_i); #1;
    checks++; if (busy_p !== 1'b0) begin failures++; $display("FAIL rstout_after: got busy=%0b expected 0", busy_p); end
    $display("test_reset_outstanding done");
  endtask

  initial begin
    idle_p();
    idle_r();
    test_reset();
    test_single_fetch();
    test_data_priority();
    test_round_robin();
    test_lock();
    test_full_gating();
    test_reset_outstanding();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
